fl: RTL

//  Physical-register free list, the producer end of the rename interface: it supplies fl_pr0/fl_pr1
//  to the map table and ROB at dispatch, and takes back each retired Told from the ROB.
//  It is a circular FIFO of FL_SIZE 7-bit PR tags: pop up to 2 per cycle at head, push up to 2 per

---
 rtl/fl_pkg.sv | 26 ++
 rtl/fl_if.sv | 33 +++
 rtl/fl_ptr_inc.sv | 22 ++
 rtl/fl.sv | 88 ++++++++
 4 files changed

// File: rtl/fl_pkg.sv
// Shared constants, types and helpers for the physical-register free list.
// SD is the codebase's clock-to-q macro; it expands to nothing for synthesis.
`ifndef SD
`define SD
`endif

package fl_pkg;

    localparam int PR_NUM  = 128;
    localparam int AR_NUM  = 32;
    localparam int FL_SIZE = PR_NUM - AR_NUM;
    localparam int PTR_W   = 7;

    typedef logic [6:0]       pr_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [1:0]       num_t;

    localparam pr_t  ZERO_REG   = 7'd0;
    localparam ptr_t FL_SIZE_P  = ptr_t'(FL_SIZE);

    // Number of PRs the decoder may take this cycle: min(count, 2).
    function automatic num_t free_num(input ptr_t count);
        return (count >= ptr_t'(2)) ? 2'd2 : count[1:0];
    endfunction

endpackage

// File: rtl/fl_if.sv
// Rename-side interface of the free list: dispatch and retire requests in,
// allocated PR tags and status out.
interface fl_if;
    import fl_pkg::*;

    num_t id_dispatch_num;
    logic id_valid_inst0;
    logic id_valid_inst1;
    logic recover;
    num_t rob_retire_num;
    pr_t  rob_retire_told0;
    pr_t  rob_retire_told1;

    pr_t  fl_pr0;
    pr_t  fl_pr1;
    num_t fl_free_num;
    logic fl_underflow;

    // Decoder / ROB side.
    modport master (
        output id_dispatch_num, id_valid_inst0, id_valid_inst1, recover,
               rob_retire_num, rob_retire_told0, rob_retire_told1,
        input  fl_pr0, fl_pr1, fl_free_num, fl_underflow
    );

    // Free-list side.
    modport slave (
        input  id_dispatch_num, id_valid_inst0, id_valid_inst1, recover,
               rob_retire_num, rob_retire_told0, rob_retire_told1,
        output fl_pr0, fl_pr1, fl_free_num, fl_underflow
    );

endinterface

// File: rtl/fl_ptr_inc.sv
// Combinational pointer advance by 0..3 modulo FL_SIZE; the depth is not a
// power of two, so the wrap is an explicit compare-and-subtract.
module fl_ptr_inc
    import fl_pkg::*;
(
    input  ptr_t       ptr,
    input  logic [1:0] inc,
    output ptr_t       sum
);

    localparam logic [PTR_W:0] SIZE_EXT = (PTR_W+1)'(FL_SIZE);

    logic [PTR_W:0] raw;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        raw = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, inc};
        sum = (raw >= SIZE_EXT) ? ptr_t'(raw - SIZE_EXT) : ptr_t'(raw);
    end

endmodule

// File: rtl/fl.sv
// Physical-register free list: circular FIFO of PR tags, two pops at head for
// dispatch, two pushes at tail for retire, single-cycle reclaim on recover.
module fl
    import fl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    fl_if.slave  bus
);

    pr_t  entry [FL_SIZE];
    ptr_t head;
    ptr_t tail;
    ptr_t count;
    logic underflow_q;

    logic [1:0]     pop;
    logic [1:0]     push;
    logic           pop_ok;
    logic [1:0]     pop_eff;
    logic [PTR_W:0] count_sum;
    ptr_t           count_next;
    ptr_t           head_p1;
    ptr_t           head_pop;
    ptr_t           tail_p1;
    ptr_t           tail_push;

    fl_ptr_inc u_head_p1   (.ptr(head), .inc(2'd1), .sum(head_p1));
    fl_ptr_inc u_head_pop  (.ptr(head), .inc(pop),  .sum(head_pop));
    fl_ptr_inc u_tail_p1   (.ptr(tail), .inc(2'd1), .sum(tail_p1));
    fl_ptr_inc u_tail_push (.ptr(tail), .inc(push), .sum(tail_push));

    // An invalid inst0 consumes nothing, so inst1 then takes entry[head].
    always_comb begin
        pop  = {1'b0, (bus.id_dispatch_num != 2'd0) & bus.id_valid_inst0}
             + {1'b0, (bus.id_dispatch_num == 2'd2) & bus.id_valid_inst1};
        push = bus.rob_retire_num;

        // Pop is judged against the pre-push count; same-cycle retires do not help.
        pop_ok  = ({{(PTR_W-2){1'b0}}, pop} <= count);
        pop_eff = pop_ok ? pop : 2'd0;

        count_sum = {1'b0, count} + {{(PTR_W-1){1'b0}}, push}
                  - {{(PTR_W-1){1'b0}}, pop_eff};
        count_next = (count_sum > {1'b0, FL_SIZE_P}) ? FL_SIZE_P : count_sum[PTR_W-1:0];
    end

    always_comb begin
        bus.fl_pr0       = entry[head];
        bus.fl_pr1       = bus.id_valid_inst0 ? entry[head_p1] : entry[head];
        bus.fl_free_num  = free_num(count);
        bus.fl_underflow = underflow_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tag storage is reset on purpose: the free list must start
            // holding PRs AR_NUM..PR_NUM-1, so this is functional state, not a RAM.
            for (int i = 0; i < FL_SIZE; i++) begin
                entry[i] <= `SD pr_t'(AR_NUM + i);
            end
            head        <= `SD '0;
            tail        <= `SD '0;
            count       <= `SD FL_SIZE_P;
            underflow_q <= `SD 1'b0;
        end else if (bus.recover) begin
            // Slots [tail, head) still hold every in-flight PR in allocation order.
            head        <= `SD tail;
            count       <= `SD FL_SIZE_P;
            underflow_q <= `SD 1'b0;
        end else begin
            if (push != 2'd0) begin
                entry[tail] <= `SD bus.rob_retire_told0;
            end
            if (push == 2'd2) begin
                entry[tail_p1] <= `SD bus.rob_retire_told1;
            end
            // On underflow only the pop is dropped; retired tags are still kept.
            head        <= `SD pop_ok ? head_pop : head;
            tail        <= `SD tail_push;
            count       <= `SD count_next;
            underflow_q <= `SD ~pop_ok;
        end
    end

endmodule
